// File: rtl/sram_burst_pkg.sv
// Shared types and constants for the burst SRAM target.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    BURST
  } state_t;

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned BEAT_W = 6;

  localparam int unsigned BL_CONT = 0;
  localparam int unsigned BL_4    = 4;
  localparam int unsigned BL_8    = 8;
  localparam int unsigned BL_16   = 16;
  localparam int unsigned BL_32   = 32;

  // Ceiling log2; used to size the wrap mask for a power-of-two burst length.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_burst_target_addr_gen.sv
// Loadable burst address counter.
// SRAM_TGT_WRAP_EN: wrap inside the BURST_LEN-aligned block (linear when BURST_LEN=0).
module burst_addr_gen
  import sram_burst_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               inc,
  input  logic [A_WIDTH-1:0] load_addr,
  output logic [A_WIDTH-1:0] addr,
  output logic [A_WIDTH-1:0] addr_next
);

  localparam logic [A_WIDTH-1:0] ONES = '1;

  // Bits under the mask increment, bits outside it hold; an all-ones mask is a plain +1.
`ifdef SRAM_TGT_WRAP_EN
  localparam logic [A_WIDTH-1:0] WRAP_MASK =
    (BURST_LEN == 0) ? ONES : A_WIDTH'((32'd1 << log2(BURST_LEN)) - 32'd1);
`else
  localparam logic [A_WIDTH-1:0] WRAP_MASK = ONES;
`endif

  logic [A_WIDTH-1:0] addr_inc;

  always_comb begin
    addr_inc  = (addr & ~WRAP_MASK) | ((addr + A_WIDTH'(1)) & WRAP_MASK);
    addr_next = addr;
    if (load)     addr_next = load_addr;
    else if (inc) addr_next = addr_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr <= '0;
    else     addr <= addr_next;
  end

endmodule

// File: rtl/sram_burst_target.sv
// Synchronous burst SRAM target backed by an internal register array.
// Optional macro: SRAM_TGT_WRAP_EN (burst-aligned address wrap).
module sram_burst_target
  import sram_burst_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 16,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               adv,
  input  logic               we,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [D_WIDTH-1:0] rdata,
  output logic               dvalid,
  output logic               dwait
);

  localparam logic [LAT_W-1:0]  LAT_INIT  = (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;
  localparam logic [BEAT_W-1:0] BEAT_LAST = (BURST_LEN > 0) ? BEAT_W'(BURST_LEN - 1) : '0;
  localparam bit                CONT      = (BURST_LEN == 0);

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                we_q, we_d;
  logic                load, inc, wr_en;
  logic [A_WIDTH-1:0]  addr_q, addr_d;
  logic [D_WIDTH-1:0]  mem [2**A_WIDTH];

  burst_addr_gen #(
    .A_WIDTH   (A_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .inc       (inc),
    .load_addr (addr),
    .addr      (addr_q),
    .addr_next (addr_d)
  );

  assign dvalid = (state_q == BURST);
  assign dwait  = (state_q == LAT);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    we_d    = we_q;
    load    = 1'b0;
    inc     = 1'b0;
    wr_en   = (state_q == BURST) && cs && we_q;
    if (!cs) begin
      state_d = IDLE;
      lat_d   = '0;
      beat_d  = '0;
    end else if (adv) begin
      load    = 1'b1;
      we_d    = we;
      beat_d  = '0;
      lat_d   = LAT_INIT;
      state_d = (LATENCY == 1) ? BURST : LAT;
    end else begin
      case (state_q)
        LAT: begin
          if (lat_q == '0) state_d = BURST;
          else             lat_d   = lat_q - LAT_W'(1);
        end
        BURST: begin
          inc = 1'b1;
          if (!CONT && beat_q == BEAT_LAST) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
    end
  end

  // Prefetch: the word for the next beat is read on the edge that moves to it, so
  // rdata is already valid during each beat and holds once the burst ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             rdata <= '0;
    else if (state_d == BURST && !we_d)  rdata <= mem[addr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= wdata;
  end

endmodule

// File: tb/tb_sram_burst_target.sv
// Directed bench for sram_burst_target (LATENCY=3/BL=4 and LATENCY=1/continuous).
module tb_sram_burst_target;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

`ifdef SRAM_TGT_WRAP_EN
  localparam logic [DW-1:0] FE_B2 = 16'hC0C0, FE_B3 = 16'hC1C1;
  localparam logic [DW-1:0] S6_B2 = 16'hE4E4, S6_B3 = 16'hE5E5;
`else
  localparam logic [DW-1:0] FE_B2 = 16'hD0D0, FE_B3 = 16'hD1D1;
  localparam logic [DW-1:0] S6_B2 = 16'hE8E8, S6_B3 = 16'hE9E9;
`endif

  logic clk;
  logic rst;
  logic cs, adv, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic dvalid, dwait;
  logic c_cs, c_adv, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic c_dvalid, c_dwait;

  int checks;
  int errors;

  typedef struct {
    logic          cs, adv, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            chk_ctl;
    logic          dv, dw;
    bit            chk_rd;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vq[$];

  sram_burst_target #(
    .D_WIDTH   (DW),
    .A_WIDTH   (AW),
    .LATENCY   (3),
    .BURST_LEN (4)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .adv    (adv),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .dvalid (dvalid),
    .dwait  (dwait)
  );

  sram_burst_target #(
    .D_WIDTH   (DW),
    .A_WIDTH   (AW),
    .LATENCY   (1),
    .BURST_LEN (0)
  ) u_cont (
    .clk    (clk),
    .rst    (rst),
    .cs     (c_cs),
    .adv    (c_adv),
    .we     (c_we),
    .addr   (c_addr),
    .wdata  (c_wdata),
    .rdata  (c_rdata),
    .dvalid (c_dvalid),
    .dwait  (c_dwait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string what, input int idx, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", what, idx, got, exp);
    end
  endtask

  function automatic void add(input logic c, input logic a, input logic w,
                              input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                              input bit cc, input logic dv, input logic dw,
                              input bit cr, input logic [DW-1:0] rd);
    vec_t v;
    v.cs = c; v.adv = a; v.we = w; v.addr = ad; v.wdata = wd;
    v.chk_ctl = cc; v.dv = dv; v.dw = dw; v.chk_rd = cr; v.rd = rd;
    vq.push_back(v);
  endfunction

  // Full LATENCY=3, 4-beat burst: adv cycle, two wait cycles, four beats.
  function automatic void push_burst(input logic wr, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                     input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    logic [DW-1:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    add(1, 1, wr, a, '0, 1, 0, 0, 0, '0);
    add(1, 0, wr, a, '0, 1, 0, 1, 0, '0);
    add(1, 0, wr, a, '0, 1, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++)
      add(1, 0, wr, a, wr ? d[i] : 16'hDEAD, 1, 1, 0, !wr, d[i]);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cs = 0; adv = 0; we = 0; addr = '0; wdata = '0;
    c_cs = 0; c_adv = 0; c_we = 0; c_addr = '0; c_wdata = '0;

    #12;
    check("reset_rdata", 0, rdata, '0);
    check("reset_dvalid", 0, DW'(dvalid), '0);
    check("reset_dwait", 0, DW'(dwait), '0);
    check("reset_c_rdata", 0, c_rdata, '0);
    check("reset_c_dvalid", 0, DW'(c_dvalid), '0);
    rst = 1'b0;

    // write then read back at 0x10
    push_burst(1, 8'h10, 16'hA101, 16'hA202, 16'hA303, 16'hA404);
    push_burst(0, 8'h10, 16'hA101, 16'hA202, 16'hA303, 16'hA404);
    // aligned fills, then unaligned reads that show linear vs wrapped order
    push_burst(1, 8'hFC, 16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3);
    push_burst(1, 8'h00, 16'hD0D0, 16'hD1D1, 16'hD2D2, 16'hD3D3);
    push_burst(1, 8'h04, 16'hE4E4, 16'hE5E5, 16'hE6E6, 16'hE7E7);
    push_burst(1, 8'h08, 16'hE8E8, 16'hE9E9, 16'hEAEA, 16'hEBEB);
    push_burst(0, 8'hFE, 16'hC2C2, 16'hC3C3, FE_B2, FE_B3);
    push_burst(0, 8'h06, 16'hE6E6, 16'hE7E7, S6_B2, S6_B3);
    // cs dropped after two beats of a write to 0x20
    push_burst(1, 8'h20, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    add(1, 1, 1, 8'h20, '0, 1, 0, 0, 0, '0);
    add(1, 0, 1, 8'h20, '0, 1, 0, 1, 0, '0);
    add(1, 0, 1, 8'h20, '0, 1, 0, 1, 0, '0);
    add(1, 0, 1, 8'h20, 16'h5555, 1, 1, 0, 0, '0);
    add(1, 0, 1, 8'h20, 16'h6666, 1, 1, 0, 0, '0);
    add(0, 0, 1, 8'h20, 16'h7777, 0, 0, 0, 0, '0);
    add(0, 0, 0, 8'h20, 16'h8888, 1, 0, 0, 0, '0);
    add(0, 0, 0, 8'h20, 16'h8888, 1, 0, 0, 0, '0);
    push_burst(0, 8'h20, 16'h5555, 16'h6666, 16'h3333, 16'h4444);
    // read 0x40 restarts a write to 0x30 during its latency
    push_burst(1, 8'h30, 16'h3131, 16'h3232, 16'h3333, 16'h3434);
    push_burst(1, 8'h40, 16'h4141, 16'h4242, 16'h4343, 16'h4444);
    add(1, 1, 1, 8'h30, 16'h9999, 1, 0, 0, 0, '0);
    add(1, 1, 0, 8'h40, 16'h9999, 1, 0, 1, 0, '0);
    add(1, 0, 0, 8'h40, 16'h9999, 1, 0, 1, 0, '0);
    add(1, 0, 0, 8'h40, 16'h9999, 1, 0, 1, 0, '0);
    add(1, 0, 0, 8'h40, 16'h9999, 1, 1, 0, 1, 16'h4141);
    add(1, 0, 0, 8'h40, 16'h9999, 1, 1, 0, 1, 16'h4242);
    add(1, 0, 0, 8'h40, 16'h9999, 1, 1, 0, 1, 16'h4343);
    add(1, 0, 0, 8'h40, 16'h9999, 1, 1, 0, 1, 16'h4444);
    push_burst(0, 8'h30, 16'h3131, 16'h3232, 16'h3333, 16'h3434);
    // rdata holds after the burst
    add(0, 0, 0, '0, '0, 1, 0, 0, 1, 16'h3434);
    add(1, 0, 0, '0, '0, 1, 0, 0, 1, 16'h3434);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      cs = vq[i].cs; adv = vq[i].adv; we = vq[i].we;
      addr = vq[i].addr; wdata = vq[i].wdata;
      @(negedge clk);
      if (vq[i].chk_ctl) begin
        check("vec_dvalid", i, DW'(dvalid), DW'(vq[i].dv));
        check("vec_dwait", i, DW'(dwait), DW'(vq[i].dw));
      end
      if (vq[i].chk_rd) check("vec_rdata", i, rdata, vq[i].rd);
    end

    // async reset in the middle of a read burst
    @(posedge clk); #1;
    cs = 1; adv = 1; we = 0; addr = 8'h10;
    @(posedge clk); #1; adv = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstburst_pre_dvalid", 0, DW'(dvalid), 16'h0001);
    check("rstburst_pre_rdata", 0, rdata, 16'hA101);
    rst = 1'b1; #1;
    check("rstburst_rdata", 0, rdata, '0);
    check("rstburst_dvalid", 0, DW'(dvalid), '0);
    check("rstburst_dwait", 0, DW'(dwait), '0);
    @(posedge clk); #1; rst = 1'b0; adv = 0;
    @(negedge clk);
    check("rstburst_idle_dvalid", 0, DW'(dvalid), '0);
    check("rstburst_idle_dwait", 0, DW'(dwait), '0);

    // async reset during latency
    @(posedge clk); #1; adv = 1; addr = 8'h10;
    @(posedge clk); #1; adv = 0;
    @(negedge clk);
    check("rstlat_pre_dwait", 0, DW'(dwait), 16'h0001);
    rst = 1'b1; #1;
    check("rstlat_dwait", 0, DW'(dwait), '0);
    @(posedge clk); #1; rst = 1'b0; cs = 0;

    // continuous bursts, LATENCY=1: write 00..08, then read them back
    @(posedge clk); #1;
    c_cs = 1; c_adv = 1; c_we = 1; c_addr = 8'h00;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      c_adv = 0; c_wdata = 16'h6000 + 16'(i);
      @(negedge clk);
      check("cont_wr_dvalid", i, DW'(c_dvalid), 16'h0001);
      check("cont_wr_dwait", i, DW'(c_dwait), '0);
    end
    @(posedge clk); #1; c_cs = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("cont_wr_end_dvalid", 0, DW'(c_dvalid), '0);
    @(posedge clk); #1;
    c_cs = 1; c_adv = 1; c_we = 0; c_addr = 8'h00;
    @(negedge clk);
    check("cont_rd_adv_dvalid", 0, DW'(c_dvalid), '0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      c_adv = 0;
      @(negedge clk);
      check("cont_rd_dvalid", i, DW'(c_dvalid), 16'h0001);
      check("cont_rd_rdata", i, c_rdata, 16'h6000 + 16'(i));
    end
    @(posedge clk); #1; c_cs = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("cont_rd_end_dvalid", 0, DW'(c_dvalid), '0);
    check("cont_rd_end_dwait", 0, DW'(c_dwait), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
